mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; ports listed clock and reset first:
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 cpu_req  input  1  CPU access request; cpu_we/cpu_addr/cpu_wdata held stable while high.
REQ-005 cpu_we  input  1  1=write, 0=read.
REQ-006 cpu_addr  input  32  CPU byte address.
REQ-007 cpu_wdata  input  32  CPU write data.
REQ-008 cpu_rdata  output  32  registered CPU read data.
REQ-009 cpu_ready  output  1  one-cycle completion pulse to CPU.
REQ-010 dma_req, dma_we, dma_addr[31:0], dma_wdata[31:0]  input  same meaning as CPU ports, DMA/loader requester.
REQ-011 dma_rdata  output  32; dma_ready  output  1; same meaning as CPU ports.
REQ-012 cpu_gnt, dma_gnt  output  1  high while that requester owns the memory (ISSUE, RESP, DONE).
REQ-013 mem_en  output  1  memory access strobe; mem_we  output  1  write enable.
REQ-014 mem_addr  output  32; mem_wdata  output  32; mem_rdata  input  32, valid the cycle after mem_en with mem_we=0.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, RESP, DONE; one grant register (CPU/DMA) and one last_grant register.
REQ-016 IDLE: no request -> stay; one request -> grant it, go ISSUE; both -> grant requester not equal to last_grant, go ISSUE; last_grant updated to the winner on that edge.
REQ-017 ISSUE: mem_en=1; mem_we/mem_addr/mem_wdata muxed from granted requester's inputs; next state RESP.
REQ-018 RESP: mem_en=0; for a read, granted rdata register SHALL load mem_rdata at end of cycle; for a write, rdata registers SHALL hold; next state DONE.
REQ-019 DONE: granted requester's ready=1 for exactly this cycle; next state IDLE unconditionally.
REQ-020 Latency: req first sampled high in IDLE cycle t -> mem_en at t+1 -> ready and valid rdata at t+3; one access per 4 cycles minimum.
REQ-021 Outside ISSUE, mem_en and mem_we SHALL be 0; mem_addr/mem_wdata are don't-care but SHALL not be X after reset (drive 0 in IDLE).
REQ-022 Non-granted requester's ready SHALL stay 0 and its rdata SHALL hold.
REQ-023 Requests changing or dropping while granted SHALL not abort the access; ISSUE uses values present in ISSUE cycle.
REQ-024 Requester re-raising req in the cycle after its ready SHALL be evaluated normally in IDLE, with round-robin still applied against a waiting peer.
REQ-025 cpu_gnt and dma_gnt SHALL never be high together; both 0 in IDLE.
REQ-026 Requests arriving in ISSUE/RESP/DONE SHALL wait; no request is lost while req stays high.

Reset
REQ-027 On reset: state=IDLE, last_grant=DMA (CPU wins first tie), cpu_ready=dma_ready=0, cpu_gnt=dma_gnt=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, cpu_rdata=dma_rdata=0.
REQ-028 Reset asserted mid-access (ISSUE/RESP/DONE) SHALL abort it: no ready pulse, rdata to 0, IDLE next cycle, no mem_en in the cycle after reset.

Verification
REQ-029 CPU read alone: cpu_req=1, cpu_we=0, cpu_addr=0x100, memory returns 0xDEADBEEF -> mem_en=1 at t+1 with addr 0x100, cpu_ready=1 and cpu_rdata=0xDEADBEEF at t+3, dma_ready=0.
REQ-030 DMA write alone: dma_we=1, dma_addr=0x200, dma_wdata=0x12345678 -> mem_en=mem_we=1, matching addr/data at t+1; dma_ready at t+3; dma_rdata unchanged.
REQ-031 Simultaneous requests after reset, both held -> grants CPU, DMA, CPU, DMA in 4-cycle slots; ready pulses alternate.
REQ-032 CPU request continuously high while DMA idle -> back-to-back CPU accesses every 4 cycles; DMA request raised later served in next slot.
REQ-033 Reset in RESP of a CPU read -> no cpu_ready, cpu_rdata=0, mem_en=0 next cycle, state IDLE.
REQ-034 Write then read same address (0x40, 0xA5A5A5A5) from CPU -> read returns 0xA5A5A5A5; gnt signals never overlap throughout.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU/DMA) round-robin arbiter in front of one single-ported synchronous memory.
// Latency: request seen in IDLE at cycle t -> mem_en at t+1 -> ready pulse and rdata at t+3; one access per 4 cycles.
// Backpressure: requesters hold req until their one-cycle ready pulse; a losing or late requester simply waits.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ready,
    output logic        cpu_gnt,
    output logic        dma_gnt,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;
    typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

    state_t   state;
    owner_t   grant;
    owner_t   last_grant;
    owner_t   winner;
    mem_cmd_t cpu_cmd;
    mem_cmd_t dma_cmd;
    mem_cmd_t sel_cmd;
    logic     is_read;

    assign cpu_cmd = {cpu_we, cpu_addr, cpu_wdata};
    assign dma_cmd = {dma_we, dma_addr, dma_wdata};

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        winner = OWN_CPU;
        if (cpu_req && dma_req)
            winner = (last_grant == OWN_CPU) ? OWN_DMA : OWN_CPU;
        else if (dma_req)
            winner = OWN_DMA;
    end

    // The command is taken live in ISSUE so late changes by the owner are honoured.
    assign sel_cmd   = (grant == OWN_DMA) ? dma_cmd : cpu_cmd;
    assign mem_en    = (state == ISSUE);
    assign mem_we    = mem_en & sel_cmd.we;
    assign mem_addr  = mem_en ? sel_cmd.addr  : 32'h0;
    assign mem_wdata = mem_en ? sel_cmd.wdata : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= OWN_CPU;
            last_grant <= OWN_DMA;
            is_read    <= 1'b0;
            cpu_gnt    <= 1'b0;
            dma_gnt    <= 1'b0;
            cpu_ready  <= 1'b0;
            dma_ready  <= 1'b0;
            cpu_rdata  <= 32'h0;
            dma_rdata  <= 32'h0;
        end else begin
            cpu_ready <= 1'b0;
            dma_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        grant      <= winner;
                        last_grant <= winner;
                        cpu_gnt    <= (winner == OWN_CPU);
                        dma_gnt    <= (winner == OWN_DMA);
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    is_read <= ~sel_cmd.we;
                    state   <= RESP;
                end
                RESP: begin
                    // Memory read data is valid in this cycle only; writes leave rdata untouched.
                    if (is_read) begin
                        if (grant == OWN_CPU)
                            cpu_rdata <= mem_rdata;
                        else
                            dma_rdata <= mem_rdata;
                    end
                    cpu_ready <= (grant == OWN_CPU);
                    dma_ready <= (grant == OWN_DMA);
                    state     <= DONE;
                end
                DONE: begin
                    cpu_gnt <= 1'b0;
                    dma_gnt <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level slot model feeds a scoreboard, negedge monitor checks.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        req_s   [2];
    logic        we_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ready, dma_ready, cpu_gnt, dma_gnt, mem_en, mem_we;
    logic [1:0]  rdy;

    assign rdy = {dma_ready, cpu_ready};

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (req_s[0]),
        .cpu_we    (we_s[0]),
        .cpu_addr  (addr_s[0]),
        .cpu_wdata (wdata_s[0]),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .dma_req   (req_s[1]),
        .dma_we    (we_s[1]),
        .dma_addr  (addr_s[1]),
        .dma_wdata (wdata_s[1]),
        .dma_rdata (dma_rdata),
        .dma_ready (dma_ready),
        .cpu_gnt   (cpu_gnt),
        .dma_gnt   (dma_gnt),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        int          who;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          due_mem;
        int          due_rdy;
    } exp_t;

    exp_t        mq[$];
    exp_t        rq[$];
    int          served[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] env_mem[logic [31:0]];
    logic [31:0] exp_rd[2] = '{32'h0, 32'h0};
    int          busy = 0;
    int          own = 0;
    int          last = 1;
    int          cyc = 0;
    bit          reset_d = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          seen;
    int          n0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        reset_d <= reset;
    end

    function automatic logic [31:0] dflt(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Memory environment: writes land on mem_en, read data appears one cycle later, garbage otherwise.
    initial forever begin
        @(posedge clk);
        if (mem_en && mem_we) env_mem[mem_addr] = mem_wdata;
        if (mem_en && !mem_we)
            mem_rdata <= env_mem.exists(mem_addr) ? env_mem[mem_addr] : dflt(mem_addr);
        else
            mem_rdata <= $urandom;
    end

    // Reference: the port is either free or busy for 3 more cycles after a grant decision.
    initial begin : model
        exp_t me;
        int   w;
        forever begin
            @(posedge clk);
            if (reset) begin
                busy = 0;
                last = 1;
                own  = 0;
                mq.delete();
                rq.delete();
            end else if (busy > 0) begin
                busy--;
            end else if (req_s[0] || req_s[1]) begin
                if (req_s[0] && req_s[1]) w = 1 - last;
                else w = req_s[0] ? 0 : 1;
                last       = w;
                own        = w;
                busy       = 3;
                me.who     = w;
                me.we      = we_s[w];
                me.addr    = addr_s[w];
                me.wdata   = wdata_s[w];
                me.due_mem = cyc + 1;
                me.due_rdy = cyc + 3;
                me.rdata   = ref_mem.exists(me.addr) ? ref_mem[me.addr] : dflt(me.addr);
                if (me.we) ref_mem[me.addr] = me.wdata;
                mq.push_back(me);
                rq.push_back(me);
            end
        end
    end

    initial begin : monitor
        exp_t pe;
        forever begin
            @(negedge clk);
            if (reset_d) begin
                exp_rd[0] = 32'h0;
                exp_rd[1] = 32'h0;
                chk("reset_ctrl", {26'h0, mem_en, mem_we, cpu_ready, dma_ready, cpu_gnt, dma_gnt}, 32'h0);
                chk("reset_mem_addr", mem_addr, 32'h0);
                chk("reset_mem_wdata", mem_wdata, 32'h0);
            end
            chk("gnt", {30'h0, cpu_gnt, dma_gnt}, {30'h0, busy > 0 && own == 0, busy > 0 && own == 1});
            if (mem_en) begin
                if (mq.size() == 0) begin
                    chk("mem_en_unexpected", {31'h0, mem_en}, 32'h0);
                end else begin
                    pe = mq.pop_front();
                    chk("mem_cycle", cyc, pe.due_mem);
                    chk("mem_we", {31'h0, mem_we}, {31'h0, pe.we});
                    chk("mem_addr", mem_addr, pe.addr);
                    if (pe.we) chk("mem_wdata", mem_wdata, pe.wdata);
                end
            end else begin
                chk("mem_we_idle", {31'h0, mem_we}, 32'h0);
                if (busy == 0) chk("mem_addr_idle", mem_addr, 32'h0);
                if (mq.size() > 0 && mq[0].due_mem <= cyc) begin
                    chk("mem_en_missing", {31'h0, mem_en}, 32'h1);
                    pe = mq.pop_front();
                end
            end
            if (rdy != 2'b00) begin
                if (rq.size() == 0) begin
                    chk("ready_unexpected", {30'h0, rdy}, 32'h0);
                end else begin
                    pe = rq.pop_front();
                    chk("ready_who", {30'h0, rdy}, (pe.who == 0) ? 32'h1 : 32'h2);
                    chk("ready_cycle", cyc, pe.due_rdy);
                    served.push_back(pe.who);
                    if (!pe.we) exp_rd[pe.who] = pe.rdata;
                end
            end else if (rq.size() > 0 && rq[0].due_rdy <= cyc) begin
                chk("ready_missing", {30'h0, rdy}, (rq[0].who == 0) ? 32'h1 : 32'h2);
                pe = rq.pop_front();
            end
            chk("cpu_rdata", cpu_rdata, exp_rd[0]);
            chk("dma_rdata", dma_rdata, exp_rd[1]);
        end
    end

    // Raise a request after 'gap' cycles and hold it until the ready pulse (bounded).
    task automatic do_txn(input int w, input bit we, input logic [31:0] a, input logic [31:0] d, input int gap);
        bit ok;
        repeat (gap) @(negedge clk);
        req_s[w]   = 1'b1;
        we_s[w]    = we;
        addr_s[w]  = a;
        wdata_s[w] = d;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (rdy[w]) ok = 1'b1;
        end
        req_s[w] = 1'b0;
        chk("txn_completed", {31'h0, ok}, 32'h1);
    endtask

    task automatic rand_txn(input int w);
        do_txn(w, 1'($urandom_range(0, 1)), 32'h40 + 32'($urandom_range(0, 15)) * 4, $urandom,
               int'($urandom_range(0, 4)));
    endtask

    initial begin : stim
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_s[i]   = 1'b0;
            we_s[i]    = 1'b0;
            addr_s[i]  = 32'h0;
            wdata_s[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;

        do_txn(0, 1'b0, 32'h100, 32'h0, 0);
        chk("cpu_read_deadbeef", cpu_rdata, 32'hDEADBEEF);
        chk("dma_ready_quiet", {31'h0, dma_ready}, 32'h0);

        do_txn(1, 1'b1, 32'h200, 32'h12345678, 0);
        chk("dma_write_rdata_hold", dma_rdata, 32'h0);

        n0 = served.size();
        fork
            begin
                do_txn(0, 1'b0, 32'h10, 32'h0, 0);
                do_txn(0, 1'b0, 32'h14, 32'h0, 0);
            end
            begin
                do_txn(1, 1'b0, 32'h18, 32'h0, 0);
                do_txn(1, 1'b0, 32'h1C, 32'h0, 0);
            end
        join
        chk("rr_served_count", served.size() - n0, 32'd4);
        if (served.size() >= n0 + 4)
            for (int k = 0; k < 4; k++) chk("rr_order", served[n0 + k], k % 2);

        fork
            begin
                do_txn(0, 1'b0, 32'h20, 32'h0, 0);
                do_txn(0, 1'b1, 32'h24, $urandom, 0);
                do_txn(0, 1'b0, 32'h24, 32'h0, 0);
            end
            do_txn(1, 1'b1, 32'h28, $urandom, 5);
        join

        fork
            do_txn(0, 1'b0, 32'h104, 32'h0, 0);
            begin
                seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    if (mem_en) seen = 1'b1;
                end
                chk("abort_issue_seen", {31'h0, seen}, 32'h1);
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("abort_no_ready", {31'h0, cpu_ready}, 32'h0);
                chk("abort_rdata_zero", cpu_rdata, 32'h0);
                chk("abort_no_mem_en", {31'h0, mem_en}, 32'h0);
                chk("abort_gnt_low", {31'h0, cpu_gnt}, 32'h0);
            end
        join

        do_txn(0, 1'b1, 32'h40, 32'hA5A5A5A5, 0);
        do_txn(0, 1'b0, 32'h40, 32'h0, 0);
        chk("write_then_read", cpu_rdata, 32'hA5A5A5A5);

        fork
            for (int i = 0; i < 25; i++) rand_txn(0);
            for (int j = 0; j < 25; j++) rand_txn(1);
        join

        repeat (8) @(negedge clk);
        chk("scoreboard_drained", mq.size() + rq.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
